// File: rtl/branch_predictor_btb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_btb_pkg
// Description : Shared types, direction-counter encodings and PC helper for
//               the branch target buffer / direction predictor.
//               Contents:
//                 lc3b_bp_counter  2-bit saturating direction counter type
//                 bp_*             counter state encodings
//                 plus2()          sequential next-PC (pc + 2)
// Revision    : 1.0 - initial release
// ============================================================================
package branch_predictor_btb_pkg;

   typedef logic [1:0] lc3b_bp_counter;

   localparam lc3b_bp_counter bp_strong_nt = 2'b00;
   localparam lc3b_bp_counter bp_weak_nt   = 2'b01;
   localparam lc3b_bp_counter bp_weak_t    = 2'b10;
   localparam lc3b_bp_counter bp_strong_t  = 2'b11;

   // Fall-through PC of a 16-bit instruction; used at both fetch and resolve.
   function automatic logic [15:0] plus2(input logic [15:0] pc);
      return pc + 16'd2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predictor_btb_sat_counter2.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter2
// Description : Combinational next-value of a 2-bit saturating up/down
//               counter. Counts up when inc=1, down otherwise, and holds at
//               the 00 / 11 end points.
//               Ports:
//                 ctr   in  2  current counter value
//                 inc   in  1  1: increment, 0: decrement
//                 next  out 2  saturated next value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter2
   import branch_predictor_btb_pkg::*;
(
   input  logic [1:0] ctr,
   input  logic       inc,
   output logic [1:0] next
);

   always_comb begin
      next = ctr;
      if (inc) begin
         if (ctr != bp_strong_t)
            next = ctr + 2'd1;
      end else begin
         if (ctr != bp_strong_nt)
            next = ctr - 2'd1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/branch_predictor_btb.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_btb
// Description : Branch target buffer with 2-bit direction counters and an
//               optional gshare index hash. Looked up combinationally at IF,
//               trained at the resolve point, which also receives the
//               mispredict flag and the corrected next PC.
//               Ports:
//                 clk, reset                   clock, async active-high reset
//                 fetch_valid/fetch_pc         IF lookup request
//                 predict_taken/target/history lookup result + history snapshot
//                 resolve_*                    retiring-instruction outcome
//                 mispredict, redirect_pc      resolve-time correction
//                 branch_count, mispredict_count saturating perf counters
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor_btb
   import branch_predictor_btb_pkg::*;
#(
   parameter int ENTRIES      = 16,
   parameter int HISTORY_BITS = 4,
   parameter int GSHARE       = 1,
   parameter int COUNT_WIDTH  = 16
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    fetch_valid,
   input  logic [15:0]             fetch_pc,
   output logic                    predict_taken,
   output logic [15:0]             predict_target,
   output logic [HISTORY_BITS-1:0] predict_history,
   input  logic                    resolve_valid,
   input  logic                    resolve_is_branch,
   input  logic                    resolve_conditional,
   input  logic                    resolve_taken,
   input  logic [15:0]             resolve_pc,
   input  logic [15:0]             resolve_target,
   input  logic                    resolve_predicted_taken,
   input  logic [15:0]             resolve_predicted_target,
   input  logic [HISTORY_BITS-1:0] resolve_history,
   output logic                    mispredict,
   output logic [15:0]             redirect_pc,
   output logic [COUNT_WIDTH-1:0]  branch_count,
   output logic [COUNT_WIDTH-1:0]  mispredict_count
);

   localparam int IDX  = $clog2(ENTRIES);
   localparam int TAGW = 15 - IDX;

   // Flop-based table, one field array per entry attribute.
   logic [ENTRIES-1:0] entry_valid;
   logic [ENTRIES-1:0] entry_uncond;
   logic [TAGW-1:0]    entry_tag    [ENTRIES];
   logic [15:0]        entry_target [ENTRIES];
   lc3b_bp_counter     entry_ctr    [ENTRIES];

   logic [HISTORY_BITS-1:0] ghr;
   logic [HISTORY_BITS:0]   ghr_shift;

   logic [IDX-1:0] fetch_idx;
   logic           fetch_hit;
   logic [IDX-1:0] res_idx;
   logic           res_hit;
   logic           eff_taken;
   lc3b_bp_counter ctr_next;

   // History is zero-extended into the low index bits before the XOR.
   function automatic logic [IDX-1:0] table_index(
      input logic [IDX-1:0]          base,
      input logic [HISTORY_BITS-1:0] hist
   );
      logic [IDX-1:0] hext;
      hext = '0;
      hext[HISTORY_BITS-1:0] = hist;
      if (GSHARE != 0)
         return base ^ hext;
      else
         return base;
   endfunction

   // ------------------------------------------------------------------ lookup
   assign fetch_idx = table_index(fetch_pc[IDX:1], ghr);
   assign fetch_hit = entry_valid[fetch_idx] &&
                      (entry_tag[fetch_idx] == fetch_pc[15:IDX+1]);

   assign predict_taken   = fetch_valid & fetch_hit &
                            (entry_uncond[fetch_idx] | entry_ctr[fetch_idx][1]);
   assign predict_target  = predict_taken ? entry_target[fetch_idx] : plus2(fetch_pc);
   assign predict_history = ghr;

   // ----------------------------------------------------------------- resolve
   // Training uses the history that was live at fetch, carried down the pipe,
   // so the entry touched is the one that produced the prediction.
   assign res_idx = table_index(resolve_pc[IDX:1], resolve_history);
   assign res_hit = entry_valid[res_idx] &&
                    (entry_tag[res_idx] == resolve_pc[15:IDX+1]);

   // A non-branch never really redirects; if it was predicted taken through
   // aliasing it mispredicts back to its fall-through PC.
   assign eff_taken  = resolve_is_branch & resolve_taken;
   assign mispredict = resolve_valid &
                       ((eff_taken != resolve_predicted_taken) |
                        (eff_taken & (resolve_target != resolve_predicted_target)));
   assign redirect_pc = eff_taken ? resolve_target : plus2(resolve_pc);

   assign ghr_shift = {ghr, resolve_taken};

   sat_counter2 u_sat_counter2 (
      .ctr  (entry_ctr[res_idx]),
      .inc  (resolve_taken),
      .next (ctr_next)
   );

   // ------------------------------------------------------------------ state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         entry_valid      <= '0;
         entry_uncond     <= '0;
         ghr              <= '0;
         branch_count     <= '0;
         mispredict_count <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            entry_tag[i]    <= '0;
            entry_target[i] <= '0;
            entry_ctr[i]    <= bp_weak_nt;
         end
      end else begin
         if (resolve_valid && resolve_is_branch) begin
            if (res_hit) begin
               entry_ctr[res_idx] <= ctr_next;
               if (resolve_taken)
                  entry_target[res_idx] <= resolve_target;
            end else if (resolve_taken) begin
               entry_valid[res_idx]  <= 1'b1;
               entry_uncond[res_idx] <= ~resolve_conditional;
               entry_tag[res_idx]    <= resolve_pc[15:IDX+1];
               entry_target[res_idx] <= resolve_target;
               entry_ctr[res_idx]    <= bp_weak_t;
            end

            if (resolve_conditional)
               ghr <= ghr_shift[HISTORY_BITS-1:0];

            if (branch_count != '1)
               branch_count <= branch_count + 1'b1;
         end else if (resolve_valid && res_hit) begin
            // Stale entry left by code that is no longer a branch.
            entry_valid[res_idx] <= 1'b0;
         end

         if (mispredict && (mispredict_count != '1))
            mispredict_count <= mispredict_count + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_btb.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor_btb
// Description : Scoreboard bench for branch_predictor_btb. Instance A is the
//               16-entry predictor (direct index); instance B is a 4-entry
//               gshare predictor with 4-bit counters. Stimulus pushes
//               expected responses into queues; the monitor pops and compares
//               whenever a request is presented to the selected instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_btb;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // Shared stimulus; valids are steered to one instance by sel.
   logic        sel;
   logic        cnt_req;
   logic        fetch_valid;
   logic [15:0] fetch_pc;
   logic        resolve_valid, resolve_is_branch, resolve_conditional, resolve_taken;
   logic [15:0] resolve_pc, resolve_target, resolve_predicted_target;
   logic        resolve_predicted_taken;
   logic [3:0]  resolve_history;

   logic        a_pt, a_mp;
   logic [15:0] a_ptgt, a_redir, a_bc, a_mc;
   logic [3:0]  a_hist;
   logic        b_pt, b_mp;
   logic [15:0] b_ptgt, b_redir;
   logic [3:0]  b_bc, b_mc;
   logic [1:0]  b_hist;

   branch_predictor_btb #(
      .ENTRIES(16), .HISTORY_BITS(4), .GSHARE(0), .COUNT_WIDTH(16)
   ) dut_a (
      .clk                      (clk),
      .reset                    (reset),
      .fetch_valid              (fetch_valid & ~sel),
      .fetch_pc                 (fetch_pc),
      .predict_taken            (a_pt),
      .predict_target           (a_ptgt),
      .predict_history          (a_hist),
      .resolve_valid            (resolve_valid & ~sel),
      .resolve_is_branch        (resolve_is_branch),
      .resolve_conditional      (resolve_conditional),
      .resolve_taken            (resolve_taken),
      .resolve_pc               (resolve_pc),
      .resolve_target           (resolve_target),
      .resolve_predicted_taken  (resolve_predicted_taken),
      .resolve_predicted_target (resolve_predicted_target),
      .resolve_history          (resolve_history),
      .mispredict               (a_mp),
      .redirect_pc              (a_redir),
      .branch_count             (a_bc),
      .mispredict_count         (a_mc)
   );

   branch_predictor_btb #(
      .ENTRIES(4), .HISTORY_BITS(2), .GSHARE(1), .COUNT_WIDTH(4)
   ) dut_b (
      .clk                      (clk),
      .reset                    (reset),
      .fetch_valid              (fetch_valid & sel),
      .fetch_pc                 (fetch_pc),
      .predict_taken            (b_pt),
      .predict_target           (b_ptgt),
      .predict_history          (b_hist),
      .resolve_valid            (resolve_valid & sel),
      .resolve_is_branch        (resolve_is_branch),
      .resolve_conditional      (resolve_conditional),
      .resolve_taken            (resolve_taken),
      .resolve_pc               (resolve_pc),
      .resolve_target           (resolve_target),
      .resolve_predicted_taken  (resolve_predicted_taken),
      .resolve_predicted_target (resolve_predicted_target),
      .resolve_history          (resolve_history[1:0]),
      .mispredict               (b_mp),
      .redirect_pc              (b_redir),
      .branch_count             (b_bc),
      .mispredict_count         (b_mc)
   );

   // ------------------------------------------------------------ scoreboard
   typedef struct { logic taken; logic [15:0] target; logic [3:0] hist; } fexp_t;
   typedef struct { logic mp; logic [15:0] redir; } rexp_t;
   typedef struct { logic [15:0] bc; logic [15:0] mc; } cexp_t;

   fexp_t fq[$];
   rexp_t rq[$];
   cexp_t cq[$];
   fexp_t fe;
   rexp_t re;
   cexp_t ce;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h (t=%0t)", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (fetch_valid) begin
         if (fq.size() == 0) chk("fetch_queue_empty", 16'd1, 16'd0);
         else begin
            fe = fq.pop_front();
            chk("predict_taken",   {15'd0, sel ? b_pt : a_pt}, {15'd0, fe.taken});
            chk("predict_target",  sel ? b_ptgt : a_ptgt, fe.target);
            chk("predict_history", {12'd0, sel ? {2'b00, b_hist} : a_hist}, {12'd0, fe.hist});
         end
      end
      if (resolve_valid) begin
         if (rq.size() == 0) chk("resolve_queue_empty", 16'd1, 16'd0);
         else begin
            re = rq.pop_front();
            chk("mispredict",  {15'd0, sel ? b_mp : a_mp}, {15'd0, re.mp});
            chk("redirect_pc", sel ? b_redir : a_redir, re.redir);
         end
      end
      if (cnt_req) begin
         if (cq.size() == 0) chk("count_queue_empty", 16'd1, 16'd0);
         else begin
            ce = cq.pop_front();
            chk("branch_count",     sel ? {12'd0, b_bc} : a_bc, ce.bc);
            chk("mispredict_count", sel ? {12'd0, b_mc} : a_mc, ce.mc);
         end
      end
   end

   // -------------------------------------------------------------- stimulus
   task automatic cyc();
      @(posedge clk);
      #1;
      fetch_valid   = 1'b0;
      resolve_valid = 1'b0;
      cnt_req       = 1'b0;
   endtask

   task automatic fet(input logic [15:0] pc, input logic et,
                      input logic [15:0] etgt, input logic [3:0] ehist);
      fexp_t f;
      fetch_valid = 1'b1;
      fetch_pc    = pc;
      f.taken = et; f.target = etgt; f.hist = ehist;
      fq.push_back(f);
   endtask

   // kind: 2'b11 conditional branch, 2'b10 unconditional, 2'b00 non-branch
   task automatic res(input logic [1:0] kind, input logic tk,
                      input logic [15:0] pc, input logic [15:0] tgt,
                      input logic pp, input logic [15:0] ppt,
                      input logic [3:0] hist,
                      input logic emp, input logic [15:0] eredir);
      rexp_t r;
      resolve_valid            = 1'b1;
      resolve_is_branch        = kind[1];
      resolve_conditional      = kind[0];
      resolve_taken            = tk;
      resolve_pc               = pc;
      resolve_target           = tgt;
      resolve_predicted_taken  = pp;
      resolve_predicted_target = ppt;
      resolve_history          = hist;
      r.mp = emp; r.redir = eredir;
      rq.push_back(r);
   endtask

   task automatic cnt(input logic [15:0] bc, input logic [15:0] mc);
      cexp_t c;
      cnt_req = 1'b1;
      c.bc = bc; c.mc = mc;
      cq.push_back(c);
   endtask

   localparam logic [1:0] COND = 2'b11, UNC = 2'b10, NB = 2'b00;

   initial begin
      reset = 1'b1; sel = 1'b0; cnt_req = 1'b0;
      fetch_valid = 1'b0; fetch_pc = '0;
      resolve_valid = 1'b0; resolve_is_branch = 1'b0; resolve_conditional = 1'b0;
      resolve_taken = 1'b0; resolve_pc = '0; resolve_target = '0;
      resolve_predicted_taken = 1'b0; resolve_predicted_target = '0; resolve_history = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // ---- instance A: training, saturation, unconditional, invalidation
      cyc(); fet(16'h3000, 0, 16'h3002, 4'h0); cnt(0, 0);
      cyc(); res(COND, 1, 16'h3000, 16'h3010, 0, 16'h3002, 4'h0, 1, 16'h3010);
      cyc(); fet(16'h3000, 1, 16'h3010, 4'h1);
      cyc(); res(COND, 0, 16'h3000, 16'h3010, 1, 16'h3010, 4'h1, 1, 16'h3002);
      cyc(); res(COND, 0, 16'h3000, 16'h3010, 0, 16'h3002, 4'h2, 0, 16'h3002);
      cyc(); fet(16'h3000, 0, 16'h3002, 4'h4);
      cyc(); res(COND, 1, 16'h3000, 16'h3010, 0, 16'h3002, 4'h4, 1, 16'h3010);
      cyc(); res(COND, 1, 16'h3000, 16'h3010, 0, 16'h3002, 4'h9, 1, 16'h3010);
      cyc(); res(COND, 1, 16'h3000, 16'h3010, 1, 16'h3010, 4'h3, 0, 16'h3010);
      cyc(); res(COND, 1, 16'h3000, 16'h3010, 1, 16'h3010, 4'h7, 0, 16'h3010);
      cyc(); res(COND, 0, 16'h3000, 16'h3010, 1, 16'h3010, 4'hF, 1, 16'h3002);
      cyc(); fet(16'h3000, 1, 16'h3010, 4'hE); cnt(8, 5);
      cyc(); res(UNC, 1, 16'h3020, 16'h3050, 0, 16'h3022, 4'hE, 1, 16'h3050);
      cyc(); fet(16'h3020, 1, 16'h3050, 4'hE);
      cyc(); fet(16'h3000, 0, 16'h3002, 4'hE);
      cyc(); res(UNC, 0, 16'h3020, 16'h3050, 1, 16'h3050, 4'hE, 1, 16'h3022);
      cyc(); res(UNC, 0, 16'h3020, 16'h3050, 1, 16'h3050, 4'hE, 1, 16'h3022);
      cyc(); fet(16'h3020, 1, 16'h3050, 4'hE); cnt(11, 8);
      cyc(); res(UNC, 1, 16'h3020, 16'h4000, 1, 16'h3050, 4'hE, 1, 16'h4000);
      cyc(); fet(16'h3020, 1, 16'h4000, 4'hE);
      cyc(); res(NB, 0, 16'h3020, 16'h0000, 1, 16'h4000, 4'hE, 1, 16'h3022);
      cyc(); fet(16'h3020, 0, 16'h3022, 4'hE); cnt(12, 10);
      // same-cycle lookup and allocate: lookup sees pre-update table
      cyc(); fet(16'h3000, 0, 16'h3002, 4'hE);
             res(COND, 1, 16'h3000, 16'h3010, 0, 16'h3002, 4'hE, 1, 16'h3010);
      cyc(); fet(16'h3000, 1, 16'h3010, 4'hD); cnt(13, 11);

      // ---- reset asserted in the middle of an allocating update
      cyc(); res(COND, 1, 16'h3024, 16'h3100, 0, 16'h3026, 4'hD, 1, 16'h3100);
      #2 reset = 1'b1;
      fet(16'h3000, 0, 16'h3002, 4'h0);
      cyc(); reset = 1'b0;
      cyc(); fet(16'h3024, 0, 16'h3026, 4'h0); cnt(0, 0);
      cyc(); fet(16'h3000, 0, 16'h3002, 4'h0);

      // ---- instance B: 4 entries, gshare, 4-bit counters
      cyc(); sel = 1'b1;
      cyc(); res(COND, 1, 16'h3002, 16'h3040, 0, 16'h3004, 4'h0, 1, 16'h3040);
      cyc(); fet(16'h3002, 0, 16'h3004, 4'h1);
      cyc(); fet(16'h3000, 1, 16'h3040, 4'h1);
      cyc(); res(COND, 0, 16'h3100, 16'h3140, 0, 16'h3102, 4'h1, 0, 16'h3102);
      cyc(); res(COND, 0, 16'h3100, 16'h3140, 0, 16'h3102, 4'h2, 0, 16'h3102);
      cyc(); fet(16'h3002, 1, 16'h3040, 4'h0);
      cyc(); fet(16'h3012, 0, 16'h3014, 4'h0);
      cyc(); res(NB, 0, 16'h3002, 16'h0000, 1, 16'h3040, 4'h0, 1, 16'h3004);
      cyc(); fet(16'h3002, 0, 16'h3004, 4'h0); cnt(3, 2);
      // training uses the carried history (11), not the live ghr (00)
      cyc(); res(COND, 1, 16'h3006, 16'h3060, 0, 16'h3008, 4'h3, 1, 16'h3060);
      cyc(); fet(16'h3006, 0, 16'h3008, 4'h1);
      cyc(); fet(16'h3002, 1, 16'h3060, 4'h1); cnt(4, 3);
      for (int i = 0; i < 13; i++) begin
         cyc(); res(NB, 0, 16'h3200, 16'h0000, 1, 16'h3300, 4'h0, 1, 16'h3202);
      end
      cyc(); cnt(4, 15);
      for (int i = 0; i < 12; i++) begin
         cyc(); res(COND, 0, 16'h3200, 16'h3300, 0, 16'h3202, 4'h0, 0, 16'h3202);
      end
      cyc(); cnt(15, 15);
      cyc(); res(NB, 0, 16'h3200, 16'h0000, 1, 16'h3300, 4'h0, 1, 16'h3202);
      cyc(); cnt(15, 15);
      cyc();
      repeat (2) @(posedge clk);

      chk("queues_drained", 16'(fq.size() + rq.size() + cq.size()), 16'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
